ysyx_220066_mem_arbiter: RTL

YSYX_220066_MEM_ARBITER -- requirements
Module: ysyx_220066_mem_arbiter

---
 rtl/ysyx_220066_mem_arbiter_pkg.sv | 30 +++
 rtl/ysyx_220066_mem_arbiter_if.sv | 44 ++++
 rtl/ysyx_220066_arb_prio.sv | 30 +++
 rtl/ysyx_220066_mem_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/ysyx_220066_mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package ysyx_220066_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STARVE_LIM_DEF = 4;

  localparam logic [2:0] MOP_LB  = 3'b000;
  localparam logic [2:0] MOP_LH  = 3'b001;
  localparam logic [2:0] MOP_LW  = 3'b010;
  localparam logic [2:0] MOP_LD  = 3'b011;
  localparam logic [2:0] MOP_LBU = 3'b100;
  localparam logic [2:0] MOP_LHU = 3'b101;
  localparam logic [2:0] MOP_LWU = 3'b110;

  // Bus data is doubleword aligned; addr[2] picks the instruction word.
  function automatic logic [31:0] fetch_word(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ysyx_220066_mem_arbiter_if.sv
// Fetch, data and shared-bus signals of the memory arbiter.
interface ysyx_220066_mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_rerr;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_op;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_rerr;

  logic        bus_req;
  logic        bus_we;
  logic [2:0]  bus_op;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;
  logic        bus_rerr;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_op, d_addr, d_wdata,
           bus_ready, bus_rvalid, bus_rdata, bus_rerr,
    output if_gnt, if_rvalid, if_rdata, if_rerr, d_gnt, d_rvalid, d_rdata, d_rerr,
           bus_req, bus_we, bus_op, bus_addr, bus_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_op, d_addr, d_wdata,
           bus_ready, bus_rvalid, bus_rdata, bus_rerr,
    input  if_gnt, if_rvalid, if_rdata, if_rerr, d_gnt, d_rvalid, d_rdata, d_rerr,
           bus_req, bus_we, bus_op, bus_addr, bus_wdata
  );
endinterface

// File: rtl/ysyx_220066_arb_prio.sv
// D-over-I priority select with a saturating starvation counter for I.
module ysyx_220066_arb_prio #(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_i,
  output logic gnt_d
);
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] cnt;
  logic          starved;

  assign starved = (cnt == CW'(STARVE_LIM));
  assign gnt_i   = idle & if_req & (starved | ~d_req);
  assign gnt_d   = idle & d_req & ~(if_req & starved);

  always_ff @(posedge clk) begin
    if (!rst)                cnt <= '0;
    else if (gnt_i)          cnt <= '0;
    else if (gnt_d & if_req) begin
      if (!starved)          cnt <= cnt + 1'b1;
    end
    else if (idle & ~if_req) cnt <= '0;
  end
endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single-outstanding memory bus.
module ysyx_220066_mem_arbiter
  import ysyx_220066_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input logic clk,
  input logic rst,
  ysyx_220066_mem_arbiter_if.slave mem
);
  state_t      state;
  owner_t      owner;
  logic        drop;
  logic        idle, gnt_i, gnt_d, done, flush_hit;
  logic        bus_req, bus_we;
  logic [2:0]  bus_op;
  logic [63:0] bus_addr, bus_wdata;
  logic        if_rvalid, if_rerr, d_rvalid, d_rerr;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata;

  // Grants are masked during reset so nothing is accepted that reset would abandon.
  assign idle = rst & (state == S_IDLE);

  ysyx_220066_arb_prio #(.STARVE_LIM(STARVE_LIM)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .if_req (mem.if_req),
    .d_req  (mem.d_req),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  assign done = ((state == S_REQ) & mem.bus_ready & mem.bus_rvalid) |
                ((state == S_WAIT) & mem.bus_rvalid);
  assign flush_hit = (owner == OWN_I) & (state != S_IDLE) & mem.if_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner     <= OWN_I;
      drop      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_op    <= 3'b000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rerr   <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rerr    <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      if_rerr   <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rerr    <= 1'b0;
      case (state)
        S_IDLE: if (gnt_i | gnt_d) begin
          state     <= S_REQ;
          bus_req   <= 1'b1;
          drop      <= 1'b0;
          owner     <= gnt_d ? OWN_D : OWN_I;
          bus_addr  <= gnt_d ? mem.d_addr : mem.if_addr;
          bus_wdata <= gnt_d ? mem.d_wdata : 64'd0;
          bus_we    <= gnt_d & mem.d_we;
          bus_op    <= gnt_d ? mem.d_op : MOP_LW;
        end
        S_REQ: if (mem.bus_ready) begin
          bus_req <= 1'b0;
          state   <= mem.bus_rvalid ? S_IDLE : S_WAIT;
        end
        S_WAIT: if (mem.bus_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (flush_hit) drop <= 1'b1;
      // A flush in the completion cycle itself also suppresses the fetch response.
      if (done) begin
        if (owner == OWN_D) begin
          d_rvalid <= 1'b1;
          d_rdata  <= mem.bus_rdata;
          d_rerr   <= mem.bus_rerr;
        end else if (!(drop | flush_hit)) begin
          if_rvalid <= 1'b1;
          if_rdata  <= fetch_word(mem.bus_rdata, bus_addr[2]);
          if_rerr   <= mem.bus_rerr;
        end
      end
    end
  end

  assign mem.if_gnt    = gnt_i;
  assign mem.d_gnt     = gnt_d;
  assign mem.bus_req   = bus_req;
  assign mem.bus_we    = bus_we;
  assign mem.bus_op    = bus_op;
  assign mem.bus_addr  = bus_addr;
  assign mem.bus_wdata = bus_wdata;
  assign mem.if_rvalid = if_rvalid;
  assign mem.if_rdata  = if_rdata;
  assign mem.if_rerr   = if_rerr;
  assign mem.d_rvalid  = d_rvalid;
  assign mem.d_rdata   = d_rdata;
  assign mem.d_rerr    = d_rerr;
endmodule
